// File: rtl/npc_pkg.sv
// Shared definitions for the fetch front end and the PC stage.
//   fetch_state_e : instruction-fetch FSM states
//   RESP_OKAY     : AXI-lite read response meaning success
//   NOP_INST      : addi x0,x0,0, substituted for faulting fetches
//   RESET_PC      : PC value the PC stage comes out of reset with
package npc_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_ADDR = 2'd1,
    FS_DATA = 2'd2,
    FS_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit sitting directly behind the PC register.
// Samples pc, issues one AR/R read at a time to instruction memory, holds the
// returned instruction for decode under a valid/ready handshake, and pulses
// pc_adv in the cycle decode consumes it. flush discards a held or in-flight
// fetch after a redirect.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   pc, fetch_en, flush : PC stage / redirect control
//   araddr, arvalid,
//   arready             : read address channel
//   rdata, rresp,
//   rvalid, rready      : read data channel
//   inst, inst_pc,
//   inst_fault,
//   inst_valid,
//   inst_ready          : decode interface
//   pc_adv              : one-cycle pulse when decode takes the instruction
module ifu_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = npc_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  input  logic              flush,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              pc_adv
);
  import npc_pkg::*;

  fetch_state_e      r_state;
  fetch_state_e      w_next;
  logic [ADDR_W-1:0] r_araddr;
  logic [ADDR_W-1:0] r_inst_pc;
  logic [DATA_W-1:0] r_inst;
  logic              r_fault;
  logic              r_drop;

  logic              w_start;
  logic              w_misalign;
  logic              w_r_hs;
  logic              w_keep;
  logic              w_consume;

  // A faulting response never reaches decode as real bits.
  function automatic logic [DATA_W-1:0] sel_inst(input logic [DATA_W-1:0] data,
                                                 input logic [1:0] resp);
    return (resp == RESP_OKAY) ? data : NOP_INST;
  endfunction

  assign w_start    = (r_state == FS_IDLE) && fetch_en && !flush;
  assign w_misalign = (pc[1:0] != 2'b00);
  assign w_r_hs     = (r_state == FS_DATA) && rvalid;
  // A flush arriving together with rvalid discards that beat as well.
  assign w_keep     = w_r_hs && !r_drop && !flush;
  assign w_consume  = (r_state == FS_HOLD) && inst_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FS_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FS_IDLE: if (w_start) w_next = w_misalign ? FS_HOLD : FS_ADDR;
      // arvalid stays up until the handshake even if a flush arrives.
      FS_ADDR: if (arready) w_next = FS_DATA;
      FS_DATA: if (rvalid)  w_next = w_keep ? FS_HOLD : FS_IDLE;
      // flush wins over inst_ready; both leave HOLD, only one advances the PC.
      FS_HOLD: if (flush || inst_ready) w_next = FS_IDLE;
      default: w_next = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_araddr  <= '0;
      r_inst_pc <= '0;
      r_inst    <= '0;
      r_fault   <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      if (w_start) begin
        r_araddr  <= pc;
        r_inst_pc <= pc;
        // Misaligned PC: no bus request, present a faulting NOP directly.
        if (w_misalign) begin
          r_inst  <= NOP_INST;
          r_fault <= 1'b1;
        end
      end
      if (w_keep) begin
        r_inst  <= sel_inst(rdata, rresp);
        r_fault <= (rresp != RESP_OKAY);
      end
      // drop marks the outstanding read as stale; cleared when its beat drains.
      if (w_r_hs)
        r_drop <= 1'b0;
      else if (flush && (r_state == FS_ADDR || r_state == FS_DATA))
        r_drop <= 1'b1;
    end
  end

  assign araddr     = r_araddr;
  assign arvalid    = (r_state == FS_ADDR);
  assign rready     = (r_state == FS_DATA);
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_fault = r_fault;
  assign inst_valid = (r_state == FS_HOLD);
  assign pc_adv     = w_consume;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
  import npc_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] pc;
  logic          fetch_en;
  logic          flush;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_fault;
  logic          inst_valid;
  logic          inst_ready;
  logic          pc_adv;

  always #5 clk = ~clk;

  ifu_fetch #(.ADDR_W(AW), .DATA_W(DW), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en), .flush(flush),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .pc_adv(pc_adv)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory responder: accepts AR after cfg_arw wait cycles, returns R
  // cfg_rw cycles after the address handshake.
  int            cfg_arw = 0;
  int            cfg_rw  = 0;
  logic [DW-1:0] cfg_d   = '0;
  logic [1:0]    cfg_resp = 2'b00;

  initial begin : responder
    int  ar_cnt;
    int  r_cnt;
    bit  r_pend;
    ar_cnt = 0; r_cnt = 0; r_pend = 0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    forever begin
      @(negedge clk or posedge rst);
      arready = 1'b0;
      rvalid  = 1'b0;
      if (rst) begin
        ar_cnt = 0; r_cnt = 0; r_pend = 0;
      end else if (r_pend) begin
        if (r_cnt == cfg_rw) begin
          rvalid = 1'b1; rdata = cfg_d; rresp = cfg_resp;
          r_pend = 0; r_cnt = 0;
        end else r_cnt++;
      end else if (arvalid) begin
        if (ar_cnt == cfg_arw) begin
          arready = 1'b1; ar_cnt = 0; r_pend = 1;
        end else ar_cnt++;
      end
    end
  end

  // Event counters sampled on the active edge.
  int ar_hs = 0, r_hs = 0, adv_cnt = 0, iv_cnt = 0;
  always @(posedge clk) begin
    if (arvalid && arready) ar_hs   <= ar_hs + 1;
    if (rvalid && rready)   r_hs    <= r_hs + 1;
    if (pc_adv)             adv_cnt <= adv_cnt + 1;
    if (inst_valid)         iv_cnt  <= iv_cnt + 1;
  end

  // Protocol-level reference: which channel the unit is waiting on, whether
  // the outstanding read is stale, and what decode should be looking at.
  bit            m_want_ar, m_want_r, m_present, m_stale;
  logic [AW-1:0] m_addr, m_ipc;
  logic [DW-1:0] m_inst;
  bit            m_fault;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_want_ar <= 0; m_want_r <= 0; m_present <= 0; m_stale <= 0;
      m_addr <= '0; m_ipc <= '0; m_inst <= '0; m_fault <= 0;
    end else if (m_present) begin
      if (flush || inst_ready) m_present <= 0;
    end else if (m_want_ar) begin
      if (flush) m_stale <= 1;
      if (arready) begin m_want_ar <= 0; m_want_r <= 1; end
    end else if (m_want_r) begin
      if (rvalid) begin
        m_want_r <= 0;
        m_stale  <= 0;
        if (!(m_stale || flush)) begin
          m_present <= 1;
          m_fault   <= (rresp != 2'b00);
          m_inst    <= (rresp != 2'b00) ? 32'h0000_0013 : rdata;
        end
      end else if (flush) m_stale <= 1;
    end else if (fetch_en && !flush) begin
      m_addr <= pc;
      m_ipc  <= pc;
      if (pc % 4 == 0) m_want_ar <= 1;
      else begin m_present <= 1; m_inst <= 32'h0000_0013; m_fault <= 1; end
    end
  end

  bit cmp_en = 0;
  initial begin : compare
    forever begin
      @(negedge clk);
      #1;
      if (cmp_en) begin
        chk("cyc_arvalid", 64'(arvalid), 64'(m_want_ar));
        chk("cyc_rready", 64'(rready), 64'(m_want_r));
        chk("cyc_inst_valid", 64'(inst_valid), 64'(m_present));
        chk("cyc_pc_adv", 64'(pc_adv), 64'(m_present && inst_ready && !flush));
        if (m_want_ar) chk("cyc_araddr", 64'(araddr), 64'(m_addr));
        if (m_present) begin
          chk("cyc_inst", 64'(inst), 64'(m_inst));
          chk("cyc_inst_pc", 64'(inst_pc), 64'(m_ipc));
          chk("cyc_inst_fault", 64'(inst_fault), 64'(m_fault));
        end
      end
    end
  end

  // One complete fetch with hand-computed expectations.
  task automatic run_fetch(input string nm, input logic [31:0] a, input int arw,
                           input int rw, input logic [31:0] d, input logic [1:0] resp,
                           input int rdyw, input int exp_lat, input logic [31:0] exp_inst,
                           input logic exp_fault, input int exp_ar);
    int            lat;
    int            n;
    int            ar0;
    int            adv0;
    logic [31:0]   s_inst;
    logic [31:0]   s_pc;
    @(negedge clk);
    cfg_arw = arw; cfg_rw = rw; cfg_d = d; cfg_resp = resp;
    pc = a; fetch_en = 1'b1; inst_ready = (rdyw == 0);
    ar0 = ar_hs; adv0 = adv_cnt; lat = 0;
    do begin
      @(negedge clk);
      fetch_en = 1'b0;
      lat++;
      #1;
      if (arvalid) chk({nm, "_araddr"}, 64'(araddr), 64'(a));
    end while (!inst_valid && lat < 40);
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_inst"}, 64'(inst), 64'(exp_inst));
    chk({nm, "_inst_pc"}, 64'(inst_pc), 64'(a));
    chk({nm, "_fault"}, 64'(inst_fault), 64'(exp_fault));
    s_inst = inst; s_pc = inst_pc;
    n = 0;
    while (!inst_ready) begin
      chk({nm, "_wait_pc_adv"}, 64'(pc_adv), 64'(0));
      chk({nm, "_wait_stable"}, {inst_valid, inst_pc, inst}, {1'b1, s_pc, s_inst});
      @(negedge clk);
      n++;
      if (n >= rdyw) inst_ready = 1'b1;
      #1;
    end
    chk({nm, "_pc_adv"}, 64'(pc_adv), 64'(1));
    @(negedge clk);
    inst_ready = 1'b0;
    #1;
    chk({nm, "_valid_drop"}, 64'(inst_valid), 64'(0));
    chk({nm, "_adv_once"}, 64'(adv_cnt - adv0), 64'(1));
    chk({nm, "_ar_count"}, 64'(ar_hs - ar0), 64'(exp_ar));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int rh0;
    int iv0;
    int adv0;
    pc = RESET_PC; fetch_en = 1'b0; flush = 1'b0; inst_ready = 1'b0;
    #1 rst = 1'b1;
    #20;
    chk("rst_arvalid", 64'(arvalid), 64'(0));
    chk("rst_rready", 64'(rready), 64'(0));
    chk("rst_inst_valid", 64'(inst_valid), 64'(0));
    chk("rst_pc_adv", 64'(pc_adv), 64'(0));
    chk("rst_inst_fault", 64'(inst_fault), 64'(0));
    chk("rst_data_regs", {araddr, inst, inst_pc}, 96'(0));
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1;

    run_fetch("basic", 32'h8000_0000, 0, 0, 32'h0010_0093, 2'b00, 0, 3, 32'h0010_0093, 1'b0, 1);
    run_fetch("slow", 32'h8000_0004, 4, 2, 32'h0020_0113, 2'b00, 0, 9, 32'h0020_0113, 1'b0, 1);
    run_fetch("stall", 32'h8000_0008, 0, 0, 32'h0030_0193, 2'b00, 5, 3, 32'h0030_0193, 1'b0, 1);

    // Flush while waiting for read data: beat drains, never presented.
    @(negedge clk);
    cfg_arw = 0; cfg_rw = 3; cfg_d = 32'hDEAD_BEEF; cfg_resp = 2'b00;
    pc = 32'h8000_0100; fetch_en = 1'b1; inst_ready = 1'b1;
    rh0 = r_hs; iv0 = iv_cnt;
    @(negedge clk);
    fetch_en = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_in_data", 64'(rready), 64'(1));
    @(negedge clk);
    flush = 1'b0; pc = 32'h8000_0200;
    repeat (5) @(negedge clk);
    #1;
    chk("flush_r_drained", 64'(r_hs - rh0), 64'(1));
    chk("flush_never_valid", 64'(iv_cnt - iv0), 64'(0));
    chk("flush_idle", {arvalid, rready, inst_valid}, 3'b000);
    run_fetch("after_flush", 32'h8000_0200, 0, 0, 32'h0040_0213, 2'b00, 0, 3, 32'h0040_0213, 1'b0, 1);

    // Error responses and misaligned PC.
    run_fetch("resp10", 32'h8000_0010, 0, 0, 32'h1234_5678, 2'b10, 0, 3, 32'h0000_0013, 1'b1, 1);
    run_fetch("resp01", 32'h8000_0014, 0, 0, 32'h1234_5678, 2'b01, 0, 3, 32'h0000_0013, 1'b1, 1);
    run_fetch("resp11", 32'h8000_0018, 1, 1, 32'h1234_5678, 2'b11, 0, 5, 32'h0000_0013, 1'b1, 1);
    run_fetch("misalign", 32'h8000_0002, 0, 0, 32'hFFFF_FFFF, 2'b00, 0, 1, 32'h0000_0013, 1'b1, 0);

    // Flush in HOLD beats inst_ready.
    @(negedge clk);
    cfg_arw = 0; cfg_rw = 0; cfg_d = 32'h0050_0293; cfg_resp = 2'b00;
    pc = 32'h8000_0020; fetch_en = 1'b1; inst_ready = 1'b0;
    adv0 = adv_cnt;
    @(negedge clk);
    fetch_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("hflush_in_hold", 64'(inst_valid), 64'(1));
    @(negedge clk);
    flush = 1'b1; inst_ready = 1'b1;
    #1 chk("hflush_no_adv", 64'(pc_adv), 64'(0));
    @(negedge clk);
    flush = 1'b0; inst_ready = 1'b0;
    #1;
    chk("hflush_valid_low", 64'(inst_valid), 64'(0));
    chk("hflush_adv_count", 64'(adv_cnt - adv0), 64'(0));

    // Asynchronous reset while the address is pending.
    @(negedge clk);
    cfg_arw = 20; pc = 32'h8000_0040; fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    #1 chk("arst_in_addr", 64'(arvalid), 64'(1));
    #1 rst = 1'b1;
    #1;
    chk("arst_arvalid", 64'(arvalid), 64'(0));
    chk("arst_inst_valid", 64'(inst_valid), 64'(0));
    chk("arst_pc_adv", 64'(pc_adv), 64'(0));
    chk("arst_araddr", 64'(araddr), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; cfg_arw = 0;
    run_fetch("post_rst", 32'h8000_0300, 0, 0, 32'h0060_0313, 2'b00, 0, 3, 32'h0060_0313, 1'b0, 1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
